// File: rtl/multdiv_sequencer_pkg.sv
// Shared constants for the multi-cycle multiply/divide unit: ALU opcodes,
// FSM state encoding and the iteration count.
package multdiv_sequencer_pkg;

  localparam int ITER = 32;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPrepA = 3'd1,
    StPrepB = 3'd2,
    StIter  = 3'd3,
    StFix   = 3'd4,
    StDone  = 3'd5
  } state_e;

endpackage

// File: rtl/multdiv_sequencer_alu.sv
// Combinational 32-bit ALU shared with the execute stage; the sequencer only
// uses its add/sub paths and the signed overflow flag.
module alu
  import multdiv_sequencer_pkg::*;
(
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic [4:0]  ctrl_ALUopcode,
  input  logic [4:0]  ctrl_shiftamt,
  output logic [31:0] data_result,
  output logic        overflow
);

  always_comb begin
    data_result = '0;
    overflow    = 1'b0;
    case (ctrl_ALUopcode)
      ALU_ADD: begin
        data_result = data_operandA + data_operandB;
        overflow    = (data_operandA[31] == data_operandB[31]) &&
                      (data_result[31] != data_operandA[31]);
      end
      ALU_SUB: begin
        data_result = data_operandA - data_operandB;
        overflow    = (data_operandA[31] != data_operandB[31]) &&
                      (data_result[31] != data_operandA[31]);
      end
      ALU_AND: data_result = data_operandA & data_operandB;
      ALU_OR:  data_result = data_operandA | data_operandB;
      ALU_SLL: data_result = data_operandA << ctrl_shiftamt;
      ALU_SRA: data_result = $signed(data_operandA) >>> ctrl_shiftamt;
      default: data_result = '0;
    endcase
  end

endmodule

// File: rtl/multdiv_sequencer.sv
// Multi-cycle signed 32-bit multiply (Booth radix-2) / divide (restoring on
// magnitudes) sequencing a single shared ALU with a start/ready handshake.
module multdiv_sequencer #(
  parameter int ITER = multdiv_sequencer_pkg::ITER
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);
  import multdiv_sequencer_pkg::*;

  state_e      state_q;
  logic [64:0] p_q;
  logic [31:0] m_q, r_q, q_q, pend_res_q;
  logic [5:0]  cnt_q;
  logic        is_div_q, sign_q, pend_exc_q;

  logic [31:0] alu_a, alu_b, alu_res;
  logic [4:0]  alu_op;
  logic        alu_ovf;

  alu u_alu (
    .data_operandA  (alu_a),
    .data_operandB  (alu_b),
    .ctrl_ALUopcode (alu_op),
    .ctrl_shiftamt  (5'd0),
    .data_result    (alu_res),
    .overflow       (alu_ovf)
  );

  logic        booth_op, sign_new, borrow, last_iter;
  logic [31:0] hi_new, r_sh;
  logic [64:0] p_nxt;

  assign r_sh      = {r_q[30:0], q_q[31]};
  assign booth_op  = p_q[1] ^ p_q[0];
  assign last_iter = (cnt_q == 6'(ITER - 1));

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    case (state_q)
      StPrepA: begin alu_b = q_q; alu_op = ALU_SUB; end
      StPrepB: begin alu_b = m_q; alu_op = ALU_SUB; end
      StFix:   begin alu_b = q_q; alu_op = ALU_SUB; end
      StIter: begin
        alu_b = m_q;
        if (is_div_q) begin
          alu_a  = r_sh;
          alu_op = ALU_SUB;
        end else begin
          alu_a  = p_q[64:33];
          alu_op = (p_q[1:0] == 2'b10) ? ALU_SUB : ALU_ADD;
        end
      end
      default: ;
    endcase
  end

  // The 33rd bit of the partial sum recovers the true sign despite 32-bit overflow.
  always_comb begin
    hi_new   = booth_op ? alu_res : p_q[64:33];
    sign_new = booth_op ? (alu_res[31] ^ alu_ovf) : p_q[64];
    p_nxt    = {sign_new, hi_new, p_q[32:1]};
    borrow   = ~r_q[31] & ((~r_sh[31] & m_q[31]) |
                           (~(r_sh[31] ^ m_q[31]) & alu_res[31]));
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      p_q            <= '0;
      m_q            <= '0;
      r_q            <= '0;
      q_q            <= '0;
      cnt_q          <= '0;
      is_div_q       <= 1'b0;
      sign_q         <= 1'b0;
      pend_res_q     <= '0;
      pend_exc_q     <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state_q)
        StIdle: begin
          if (ctrl_MULT) begin
            m_q      <= data_operandA;
            p_q      <= {32'b0, data_operandB, 1'b0};
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            state_q  <= StIter;
          end else if (ctrl_DIV) begin
            if (data_operandB == 32'd0) begin
              pend_res_q <= '0;
              pend_exc_q <= 1'b1;
              state_q    <= StDone;
            end else begin
              q_q      <= data_operandA;
              m_q      <= data_operandB;
              r_q      <= '0;
              is_div_q <= 1'b1;
              state_q  <= StPrepA;
            end
          end
        end
        StPrepA: begin
          if (q_q[31]) q_q <= alu_res;
          sign_q  <= q_q[31] ^ m_q[31];
          state_q <= StPrepB;
        end
        StPrepB: begin
          if (m_q[31]) m_q <= alu_res;
          cnt_q   <= '0;
          state_q <= StIter;
        end
        StIter: begin
          cnt_q <= cnt_q + 6'd1;
          if (is_div_q) begin
            r_q <= borrow ? r_sh : alu_res;
            q_q <= {q_q[30:0], ~borrow};
          end else begin
            p_q <= p_nxt;
            if (last_iter) begin
              pend_res_q <= p_nxt[32:1];
              pend_exc_q <= |(p_nxt[64:33] ^ {32{p_nxt[32]}});
            end
          end
          if (last_iter) state_q <= is_div_q ? StFix : StDone;
        end
        StFix: begin
          // An unsigned quotient of 2^31 only arises from -2^31 / -1.
          pend_exc_q <= ~sign_q & q_q[31];
          pend_res_q <= (~sign_q & q_q[31]) ? 32'd0 : (sign_q ? alu_res : q_q);
          state_q    <= StDone;
        end
        StDone: begin
          data_result    <= pend_res_q;
          data_exception <= pend_exc_q;
          data_resultRDY <= 1'b1;
          state_q        <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed and randomized checks of multdiv_sequencer against an arithmetic
// reference model of signed 32-bit multiply/divide.
module tb_multdiv_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;

  multdiv_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Signed reference: wide product for multiply, truncating quotient for divide.
  task automatic model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic exc);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (is_mult) begin
      p   = sa * sb;
      res = p[31:0];
      exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (sb == 0 || (sa == -64'sd2147483648 && sb == -64'sd1)) begin
      res = '0;
      exc = 1'b1;
    end else begin
      p   = sa / sb;
      res = p[31:0];
      exc = 1'b0;
    end
  endtask

  task automatic run_op(input string tag, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_exc, input int exp_lat);
    int cyc;
    bit busy_ok;
    bit seen;
    logic [31:0] held;
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    cyc     = 1;
    busy_ok = 1'b1;
    seen    = 1'b0;
    while (cyc < 100) begin
      if (data_resultRDY) begin
        seen = 1'b1;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      @(posedge clock);
      #1;
      cyc++;
    end
    chk({tag, "_rdy_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, cyc, exp_lat);
    chk({tag, "_busy_until_rdy"}, 32'(busy_ok), 32'd1);
    chk({tag, "_busy_low_at_rdy"}, 32'(busy), 32'd0);
    chk({tag, "_result"}, data_result, exp_res);
    chk({tag, "_exception"}, 32'(data_exception), 32'(exp_exc));
    held = data_result;
    @(posedge clock);
    #1;
    chk({tag, "_rdy_one_cycle"}, 32'(data_resultRDY), 32'd0);
    chk({tag, "_result_holds"}, data_result, held);
  endtask

  initial begin
    logic [31:0] ra, rb, er;
    logic        ee;
    bit          is_m;
    bit          seen;

    #12;
    chk("reset_result", data_result, 32'd0);
    chk("reset_exception", 32'(data_exception), 32'd0);
    chk("reset_rdy", 32'(data_resultRDY), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    run_op("mul_7_m3", 1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 34);
    run_op("mul_ovf_pos", 1, 0, 32'h4000_0000, 32'd4, 32'h0000_0000, 1'b1, 34);
    run_op("mul_min_m1", 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 34);
    run_op("mul_min_1", 1, 0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, 34);
    run_op("div_m7_2", 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 37);
    run_op("div_100_min", 0, 1, 32'd100, 32'h8000_0000, 32'd0, 1'b0, 37);
    run_op("div_min_m1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1, 37);
    run_op("div_5_0", 0, 1, 32'd5, 32'd0, 32'd0, 1'b1, 2);
    run_op("both_6_3", 1, 1, 32'd6, 32'd3, 32'd18, 1'b0, 34);

    // MULT start, stray DIV at cycle 10, asynchronous reset at cycle 20.
    @(negedge clock);
    data_operandA = 32'd1234;
    data_operandB = 32'd5678;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    repeat (9) begin
      @(posedge clock);
      #1;
    end
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd9;
    data_operandB = 32'd3;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    chk("abort_busy_after_div", 32'(busy), 32'd1);
    repeat (9) begin
      @(posedge clock);
      #1;
    end
    #2;
    reset = 1'b1;
    #1;
    chk("abort_result", data_result, 32'd0);
    chk("abort_exception", 32'(data_exception), 32'd0);
    chk("abort_rdy", 32'(data_resultRDY), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) seen = 1'b1;
    end
    chk("abort_no_rdy", 32'(seen), 32'd0);
    run_op("mul_3_4_after_reset", 1, 0, 32'd3, 32'd4, 32'd12, 1'b0, 34);

    for (int i = 0; i < 24; i++) begin
      is_m = (i % 2) == 0;
      ra   = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = 32'($urandom_range(0, 15));
        2: rb = -32'($urandom_range(1, 300));
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'($signed(ra) >>> 20);
      model(is_m, ra, rb, er, ee);
      run_op($sformatf("rnd%0d_%s", i, is_m ? "mul" : "div"), is_m, !is_m, ra, rb, er, ee,
             is_m ? 34 : ((rb == 32'd0) ? 2 : 37));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

- Multi-cycle signed 32-bit multiply/divide unit for the processor's execute stage.
- It owns one `alu` instance and sequences it with add/sub opcodes: Booth radix-2 for multiply, restoring division on magnitudes for divide.
- It presents the standard start-pulse / ready-pulse handshake to the pipeline stall logic.

## Interface
Parameters:
- `ITER`, 32: iteration count; equals the operand width, and the block is only specified for 32.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `data_operandA`  in  32  multiplicand / dividend, two's complement; sampled on the start edge only.
- `data_operandB`  in  32  multiplier / divisor, two's complement; sampled on the start edge only.
- `ctrl_MULT`  in  1  start multiply; honoured only in IDLE.
- `ctrl_DIV`  in  1  start divide; honoured only in IDLE.
- `data_result`  out  32  registered result; holds until the next completion.
- `data_exception`  out  1  registered; set with the result on overflow or divide-by-zero.
- `data_resultRDY`  out  1  one-cycle registered pulse; result and exception are valid in that cycle.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Reset values: all outputs 0, state IDLE, internal registers 0.
- States: IDLE, PREP_A, PREP_B, ITER, FIX, DONE.
- IDLE, start:
  - `ctrl_MULT` high: latch M=A, P={32'b0, B, 1'b0}, counter=0, go to ITER.
  - `ctrl_DIV` high with B≠0: latch operands, go to PREP_A.
  - `ctrl_DIV` high with B==0: go to DONE with exception=1, result=0.
  - Both controls high: treated as MULT.
  - Starts outside IDLE are ignored, with no queuing.
- MULT ITER, Booth step each cycle on {P[1],P[0]}:
  - 01: ALU add, hi + M.
  - 10: ALU sub, hi − M.
  - 00/11: hi passes unchanged.
  - Then arithmetic-shift the 65-bit P right by one.
  - The shifted-in sign is ALU result[31] XOR ALU overflow, so hi uses 33-bit-correct arithmetic.
  - After 32 iterations go to DONE.
  - Result is P[32:1].
  - Exception = 1 if P[64:33] is not all copies of P[32].
- DIV PREP_A: ALU sub 0 − A if A<0 into dividend magnitude register; sign_q = A[31]^B[31].
- DIV PREP_B: same for B into divisor magnitude D. 0x80000000 is kept as unsigned 2^31.
- DIV ITER:
  - t = R[31].
  - R' = {R[30:0], Q[31]}; Q shifts left.
  - ALU sub R' − D.
  - Unsigned borrow = ~t & ((~R'[31] & D[31]) | (~(R'[31]^D[31]) & diff[31])).
  - No borrow: R=diff, Q[0]=1. Borrow: R=R', Q[0]=0.
  - After 32 iterations go to FIX.
- DIV FIX:
  - sign_q=1: ALU sub 0 − Q.
  - Quotient truncates toward zero; the remainder is discarded.
  - Exception = 1 if sign_q=0 and Q[31]=1 (only −2^31 / −1); in that case result=0.
- DONE: register result/exception, pulse RDY, return to IDLE.
- Reset asserted mid-operation: abort immediately to IDLE. No RDY pulse; outputs 0.

## Timing
- Start edge = cycle 0, the edge at which IDLE samples a control.
- MULT:
  - ITER occupies cycles 1–32.
  - DONE in cycle 33.
  - RDY high in cycle 34, visible after the edge ending DONE.
- DIV:
  - PREP_A cycle 1, PREP_B cycle 2, ITER cycles 3–34, FIX cycle 35, DONE cycle 36.
  - RDY high in cycle 37.
- Divide-by-zero: DONE cycle 1, RDY in cycle 2.
- A new start is accepted in the cycle RDY is high (state is IDLE). `busy` is low in that cycle.
- Controls held high continuously restart an operation on every IDLE cycle; the pipeline is responsible for pulsing them.

## Structure
- Shared package/header:
  - ALU opcode constants: ADD=5'b00000, SUB=5'b00001.
  - State encoding localparams.
  - `ITER`.
- One sub-module: the existing `alu`, instantiated once.
  - `ctrl_shiftamt` tied 0.
  - Operand muxes and opcode are driven from state.
- The FSM and datapath registers live in `multdiv_sequencer`; there is no second sub-module.

## Test plan
- MULT A=7, B=−3 → result 0xFFFFFFEB, exception 0, RDY exactly in cycle 34, `busy` high cycles 1–33.
- MULT A=0x40000000, B=4 → exception 1. MULT A=−2^31, B=−1 → exception 1. MULT A=−2^31, B=1 → 0x80000000, exception 0.
- DIV A=−7, B=2 → 0xFFFFFFFD (−3), RDY in cycle 37. DIV A=100, B=−2^31 → 0. DIV A=−2^31, B=−1 → exception 1, result 0.
- DIV A=5, B=0 → exception 1, result 0, RDY in cycle 2.
- Start MULT, pulse `ctrl_DIV` in cycle 10, assert `reset` in cycle 20:
  - DIV is ignored.
  - All outputs are 0 immediately.
  - No RDY pulse.
  - A new MULT 3×4 after reset → 12.
- `ctrl_MULT` and `ctrl_DIV` both high with A=6, B=3 → 18 (multiply), RDY in cycle 34.
